// File: rtl/mult_reduce_arbiter.sv
// Round-robin arbiter that lends one mult_reduce datapath to NUM_REQ requesters, one whole burst at a time,
// and tags each returned result with its requester ID. Define MULT_REDUCE_ARB_FAST_REGRANT_EN for bubble-free regrant.
module mult_reduce_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 12,
   parameter int NUM_ELEMENTS  = 5,
   parameter int ID_FIFO_DEPTH = 2,
   parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid_in,
   output logic [NUM_REQ-1:0]             req_ready_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_dataa_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_datab_in,
   output logic                           mr_valid_out,
   input  logic                           mr_ready_out,
   output logic [DATA_WIDTH-1:0]          mr_dataa_out,
   output logic [DATA_WIDTH-1:0]          mr_datab_out,
   input  logic                           mr_valid_in,
   output logic                           mr_ready_in,
   input  logic [2*DATA_WIDTH-1:0]        mr_result_in,
   output logic                           res_valid_out,
   input  logic                           res_ready_out,
   output logic [2*DATA_WIDTH-1:0]        res_result_out,
   output logic [ID_WIDTH-1:0]            res_id_out,
   output logic                           err_out
);

   localparam int CNT_WIDTH = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
   localparam int PTR_WIDTH = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
   localparam int OCC_WIDTH = $clog2(ID_FIFO_DEPTH + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state, state_nxt;
   logic [ID_WIDTH-1:0]  grant, grant_nxt;
   logic [ID_WIDTH-1:0]  rr_ptr, rr_ptr_nxt, rr_after;
   logic [CNT_WIDTH-1:0] count, count_nxt;
   logic [ID_WIDTH:0]    pick;
   logic                 err;

   logic [ID_WIDTH-1:0]  fifo_mem [ID_FIFO_DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [OCC_WIDTH-1:0] occ;
   logic                 fifo_empty, push, pop;

`ifdef MULT_REDUCE_ARB_FAST_REGRANT_EN
   logic [ID_WIDTH:0]    regrant;
   logic [OCC_WIDTH:0]   occ_after_push;
`endif

   // Returns {found, index} of the first valid requester at or after start, wrapping at NUM_REQ.
   function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_WIDTH-1:0] start);
      logic                found;
      logic [ID_WIDTH-1:0] idx;
      logic [ID_WIDTH-1:0] cand;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ID_WIDTH'((int'(start) + i) % NUM_REQ);
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   assign rr_after = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
   assign pick     = rr_pick(req_valid_in, rr_ptr);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      rr_ptr_nxt   = rr_ptr;
      count_nxt    = count;
      push         = 1'b0;
      req_ready_in = '0;
      mr_valid_out = 1'b0;
      mr_dataa_out = '0;
      mr_datab_out = '0;
`ifdef MULT_REDUCE_ARB_FAST_REGRANT_EN
      regrant        = rr_pick(req_valid_in, rr_after);
      occ_after_push = {1'b0, occ} + (OCC_WIDTH+1)'(1) - (OCC_WIDTH+1)'(pop);
`endif
      case (state)
         IDLE: begin
            if (pick[ID_WIDTH] && (occ < OCC_WIDTH'(ID_FIFO_DEPTH))) begin
               grant_nxt = pick[ID_WIDTH-1:0];
               state_nxt = BURST;
            end
         end
         BURST: begin
            mr_valid_out        = req_valid_in[grant];
            mr_dataa_out        = req_dataa_in[grant*DATA_WIDTH +: DATA_WIDTH];
            mr_datab_out        = req_datab_in[grant*DATA_WIDTH +: DATA_WIDTH];
            req_ready_in[grant] = mr_ready_out;
            if (mr_valid_out && mr_ready_out) begin
               if (count == CNT_WIDTH'(NUM_ELEMENTS - 1)) begin
                  push       = 1'b1;
                  count_nxt  = '0;
                  rr_ptr_nxt = rr_after;
                  state_nxt  = IDLE;
`ifdef MULT_REDUCE_ARB_FAST_REGRANT_EN
                  // The push of this cycle counts against the slot check for the next winner.
                  if (regrant[ID_WIDTH] && (occ_after_push < (OCC_WIDTH+1)'(ID_FIFO_DEPTH))) begin
                     grant_nxt = regrant[ID_WIDTH-1:0];
                     state_nxt = BURST;
                  end
`endif
               end else begin
                  count_nxt = count + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
         count  <= '0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_ptr_nxt;
         count  <= count_nxt;
      end
   end

   // Result path: results return in burst order, so the FIFO head owns the current result.
   assign fifo_empty     = (occ == '0);
   assign res_valid_out  = mr_valid_in & ~fifo_empty;
   assign res_result_out = mr_result_in;
   assign res_id_out     = fifo_mem[rd_ptr];
   assign mr_ready_in    = res_ready_out;
   assign pop            = res_valid_out & res_ready_out;
   assign err_out        = err;

   // NOTE: ID storage is left unreset; occupancy gates every read, so stale entries are never used.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= grant;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         err    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_WIDTH'(ID_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_WIDTH'(ID_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         // A result with no committed burst behind it is a protocol violation; it still drains.
         if (mr_valid_in && fifo_empty) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mult_reduce_arbiter.sv
// Directed bench for mult_reduce_arbiter with a small behavioural mult_reduce model on the shared port.
`timescale 1ns/1ps
module tb_mult_reduce_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 12;
   localparam int NE      = 5;
   localparam int DEPTH   = 2;
   localparam int IDW     = 2;
`ifdef MULT_REDUCE_ARB_FAST_REGRANT_EN
   localparam int EXP_GAP = 1;
`else
   localparam int EXP_GAP = 2;
`endif

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [NUM_REQ-1:0]     req_valid_in = '0;
   logic [NUM_REQ-1:0]     req_ready_in;
   logic [NUM_REQ*DW-1:0]  req_dataa_in = '0;
   logic [NUM_REQ*DW-1:0]  req_datab_in = '0;
   logic                   mr_valid_out;
   logic                   mr_ready_out = 1'b1;
   logic [DW-1:0]          mr_dataa_out, mr_datab_out;
   logic                   mr_valid_in;
   logic                   mr_ready_in;
   logic [2*DW-1:0]        mr_result_in;
   logic                   res_valid_out;
   logic                   res_ready_out = 1'b1;
   logic [2*DW-1:0]        res_result_out;
   logic [IDW-1:0]         res_id_out;
   logic                   err_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   mult_reduce_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .NUM_ELEMENTS(NE), .ID_FIFO_DEPTH(DEPTH), .ID_WIDTH(IDW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_in(req_valid_in), .req_ready_in(req_ready_in),
      .req_dataa_in(req_dataa_in), .req_datab_in(req_datab_in),
      .mr_valid_out(mr_valid_out), .mr_ready_out(mr_ready_out),
      .mr_dataa_out(mr_dataa_out), .mr_datab_out(mr_datab_out),
      .mr_valid_in(mr_valid_in), .mr_ready_in(mr_ready_in), .mr_result_in(mr_result_in),
      .res_valid_out(res_valid_out), .res_ready_out(res_ready_out),
      .res_result_out(res_result_out), .res_id_out(res_id_out), .err_out(err_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural mult_reduce: accumulates NE products per burst and returns results in order.
   logic            model_valid = 1'b0;
   logic [2*DW-1:0] model_result = '0;
   logic            inject_valid = 1'b0;
   logic [2*DW-1:0] inject_result = '0;
   logic [2*DW-1:0] mq[$];
   logic [2*DW-1:0] acc = '0;
   int              beats = 0;

   assign mr_valid_in  = inject_valid | model_valid;
   assign mr_result_in = inject_valid ? inject_result : model_result;

   initial begin : mr_model
      bit            hs, pop;
      logic [DW-1:0] a, b;
      forever begin
         @(negedge clk);
         hs  = rst && mr_valid_out && mr_ready_out;
         pop = rst && model_valid && !inject_valid && mr_ready_in;
         a   = mr_dataa_out;
         b   = mr_datab_out;
         @(posedge clk);
         #1;
         if (!rst) begin
            mq.delete();
            acc   = '0;
            beats = 0;
         end else begin
            if (pop) void'(mq.pop_front());
            if (hs) begin
               acc = acc + a * b;
               beats++;
               if (beats == NE) begin
                  mq.push_back(acc);
                  acc   = '0;
                  beats = 0;
               end
            end
         end
         model_valid  = (mq.size() > 0);
         model_result = (mq.size() > 0) ? mq[0] : '0;
      end
   end

   // Handshake and result logs, sampled mid-cycle.
   int              hs_id[$];
   int              hs_cyc[$];
   int              res_id[$];
   logic [2*DW-1:0] res_val[$];
   int              multi_grant = 0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (req_valid_in[i] && req_ready_in[i]) begin
                  hs_id.push_back(i);
                  hs_cyc.push_back(cyc);
               end
            end
            if ($countones(req_ready_in) > 1) multi_grant++;
            if (res_valid_out && res_ready_out) begin
               res_id.push_back(int'(res_id_out));
               res_val.push_back(res_result_out);
            end
         end
      end
   end

   task automatic clear_logs();
      hs_id.delete();
      hs_cyc.delete();
      res_id.delete();
      res_val.delete();
      multi_grant = 0;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst           = 1'b0;
      req_valid_in  = '0;
      mr_ready_out  = 1'b1;
      res_ready_out = 1'b1;
      inject_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      clear_logs();
   endtask

   task automatic wait_hs(input int n, input int budget, output bit ok);
      int k = 0;
      while (hs_id.size() < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      ok = (hs_id.size() >= n);
   endtask

   task automatic wait_res(input int n, input int budget, output bit ok);
      int k = 0;
      while (res_id.size() < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      ok = (res_id.size() >= n);
   endtask

   task automatic set_req(input int i, input int a, input int b);
      req_dataa_in[i*DW +: DW] = DW'(a);
      req_datab_in[i*DW +: DW] = DW'(b);
   endtask

   task automatic test_reset();
      req_valid_in  = '1;
      mr_ready_out  = 1'b1;
      res_ready_out = 1'b1;
      inject_valid  = 1'b1;
      #2;
      n_checks++;
      if (req_ready_in !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready_in); end
      n_checks++;
      if (mr_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_mr_valid got %b want 0", mr_valid_out); end
      n_checks++;
      if (res_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid_out); end
      n_checks++;
      if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_out); end
      n_checks++;
      if (mr_ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_mr_ready_hi got %b want 1", mr_ready_in); end
      res_ready_out = 1'b0;
      #1;
      n_checks++;
      if (mr_ready_in !== 1'b0) begin n_fail++; $display("FAIL reset_mr_ready_lo got %b want 0", mr_ready_in); end
      inject_valid = 1'b0;
      req_valid_in = '0;
   endtask

   task automatic test_single();
      bit ok;
      set_req(0, 1, 2);
      req_valid_in = 4'b0001;
      for (int k = 1; k <= NE; k++) begin
         wait_hs(k, 50, ok);
         if (!ok) break;
         req_dataa_in[0 +: DW] = DW'(k + 1);
      end
      req_valid_in = '0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL single_beats got %0d want %0d", hs_id.size(), NE); end
      wait_res(1, 50, ok);
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (!ok || res_id[0] !== 0) begin n_fail++; $display("FAIL single_id got %0d want 0", ok ? res_id[0] : -1); end
      n_checks++;
      if (!ok || res_val[0] !== 24'd30) begin n_fail++; $display("FAIL single_result got %0d want 30", ok ? res_val[0] : 0); end
      n_checks++;
      if (hs_id.size() !== NE) begin n_fail++; $display("FAIL single_beat_count got %0d want %0d", hs_id.size(), NE); end
      n_checks++;
      if (err_out !== 1'b0) begin n_fail++; $display("FAIL single_err got %b want 0", err_out); end
   endtask

   task automatic test_round_robin();
      bit ok;
      int bad;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, i + 1, 3);
      req_valid_in = '1;
      wait_hs(5 * NE, 300, ok);
      req_valid_in = '0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rr_timeout got %0d beats want %0d", hs_id.size(), 5 * NE); end
      wait_res(5, 100, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rr_results got %0d want 5", res_id.size()); end
      for (int b = 0; b < 5 && hs_id.size() >= 5 * NE; b++) begin
         bad = -1;
         for (int j = 0; j < NE; j++) if (hs_id[b*NE + j] !== b % NUM_REQ) bad = hs_id[b*NE + j];
         n_checks++;
         if (bad !== -1) begin n_fail++; $display("FAIL rr_order burst %0d got id %0d want %0d", b, bad, b % NUM_REQ); end
      end
      bad = 0;
      for (int k = 1; k < hs_cyc.size() && k < 5 * NE; k++) begin
         if (hs_cyc[k] - hs_cyc[k-1] !== ((k % NE == 0) ? EXP_GAP : 1)) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL rr_spacing got %0d bad gaps want 0", bad); end
      for (int b = 0; b < 5 && res_id.size() >= 5; b++) begin
         n_checks++;
         if (res_id[b] !== b % NUM_REQ || res_val[b] !== 24'(15 * (b % NUM_REQ + 1))) begin
            n_fail++;
            $display("FAIL rr_result %0d got id %0d val %0d want id %0d val %0d",
                     b, res_id[b], res_val[b], b % NUM_REQ, 15 * (b % NUM_REQ + 1));
         end
      end
      n_checks++;
      if (multi_grant !== 0) begin n_fail++; $display("FAIL rr_multi_ready got %0d want 0", multi_grant); end
   endtask

   task automatic test_backpressure();
      bit ok;
      for (int i = 0; i < 3; i++) set_req(i, i + 1, 3);
      res_ready_out = 1'b0;
      req_valid_in  = 4'b0111;
      wait_hs(2 * NE, 200, ok);
      repeat (20) @(posedge clk);
      #1;
      n_checks++;
      if (hs_id.size() !== 2 * NE) begin n_fail++; $display("FAIL bp_stall got %0d beats want %0d", hs_id.size(), 2 * NE); end
      n_checks++;
      if (req_ready_in !== 4'b0000) begin n_fail++; $display("FAIL bp_ready got %b want 0000", req_ready_in); end
      n_checks++;
      if (res_valid_out !== 1'b1 || res_id_out !== 2'd0) begin
         n_fail++; $display("FAIL bp_head got valid %b id %0d want valid 1 id 0", res_valid_out, res_id_out);
      end
      res_ready_out = 1'b1;
      wait_res(2, 50, ok);
      n_checks++;
      if (!ok || res_id[0] !== 0 || res_id[1] !== 1) begin
         n_fail++; $display("FAIL bp_pop_order got %0d results, first ids %0d %0d want 0 1",
                            res_id.size(), ok ? res_id[0] : -1, ok ? res_id[1] : -1);
      end
      n_checks++;
      if (!ok || res_val[0] !== 24'd15 || res_val[1] !== 24'd30) begin
         n_fail++; $display("FAIL bp_pop_values got %0d %0d want 15 30", ok ? res_val[0] : 0, ok ? res_val[1] : 0);
      end
      wait_hs(2 * NE + 1, 50, ok);
      n_checks++;
      if (!ok || hs_id[2*NE] !== 2) begin n_fail++; $display("FAIL bp_resume got %0d want 2", ok ? hs_id[2*NE] : -1); end
      req_valid_in = '0;
   endtask

   task automatic test_ready_toggle();
      bit ok;
      int viol = 0;
      int k = 0;
      set_req(3, 1, 4);
      req_valid_in = 4'b1000;
      while (hs_id.size() < NE && k < 60) begin
         @(posedge clk);
         #1;
         req_dataa_in[3*DW +: DW] = DW'(hs_id.size() + 1);
         if (hs_id.size() >= NE) req_valid_in = '0;
         mr_ready_out = ~mr_ready_out;
         #1;
         if (req_ready_in[2:0] !== 3'b000 || (req_ready_in[3] && !mr_ready_out)) viol++;
         k++;
      end
      @(posedge clk);
      #1;
      req_valid_in = '0;
      mr_ready_out = 1'b1;
      wait_res(1, 50, ok);
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("FAIL toggle_ready got %0d violations want 0", viol); end
      n_checks++;
      if (hs_id.size() !== NE) begin n_fail++; $display("FAIL toggle_beats got %0d want %0d", hs_id.size(), NE); end
      n_checks++;
      if (!ok || res_id[0] !== 3 || res_val[0] !== 24'd60) begin
         n_fail++; $display("FAIL toggle_result got id %0d val %0d want id 3 val 60",
                            ok ? res_id[0] : -1, ok ? res_val[0] : 0);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      set_req(2, 7, 1);
      set_req(0, 2, 5);
      req_valid_in = 4'b0100;
      wait_hs(3, 50, ok);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (!ok || req_ready_in !== 4'b0000 || mr_valid_out !== 1'b0 || res_valid_out !== 1'b0 || err_out !== 1'b0) begin
         n_fail++; $display("FAIL async_reset got ready %b mr_valid %b res_valid %b err %b want all 0",
                            req_ready_in, mr_valid_out, res_valid_out, err_out);
      end
      req_valid_in = 4'b0101;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      clear_logs();
      wait_hs(NE, 50, ok);
      n_checks++;
      if (!ok || hs_id[0] !== 0 || hs_id[NE-1] !== 0) begin
         n_fail++; $display("FAIL async_regrant got first id %0d want 0", ok ? hs_id[0] : -1);
      end
      wait_res(1, 50, ok);
      req_valid_in = '0;
      n_checks++;
      if (!ok || res_id[0] !== 0 || res_val[0] !== 24'd50) begin
         n_fail++; $display("FAIL async_result got id %0d val %0d want id 0 val 50",
                            ok ? res_id[0] : -1, ok ? res_val[0] : 0);
      end
   endtask

   task automatic test_error();
      res_ready_out = 1'b1;
      @(posedge clk);
      #1;
      inject_result = 24'd123;
      inject_valid  = 1'b1;
      #1;
      n_checks++;
      if (res_valid_out !== 1'b0 || mr_ready_in !== 1'b1) begin
         n_fail++; $display("FAIL err_drain got res_valid %b mr_ready %b want 0 1", res_valid_out, mr_ready_in);
      end
      @(posedge clk);
      #1;
      inject_valid = 1'b0;
      n_checks++;
      if (err_out !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err_out); end
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (err_out !== 1'b1 || res_id.size() !== 0) begin
         n_fail++; $display("FAIL err_sticky got err %b results %0d want 1 0", err_out, res_id.size());
      end
      res_ready_out = 1'b0;
      #1;
      n_checks++;
      if (mr_ready_in !== 1'b0) begin n_fail++; $display("FAIL err_follow got %b want 0", mr_ready_in); end
      rst = 1'b0;
      #1;
      n_checks++;
      if (err_out !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", err_out); end
   endtask

   initial begin
      test_reset();
      apply_reset();
      test_single();
      apply_reset();
      test_round_robin();
      apply_reset();
      test_backpressure();
      apply_reset();
      test_ready_toggle();
      apply_reset();
      test_async_reset();
      apply_reset();
      test_error();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_reduce_arbiter.md
Name: mult_reduce_arbiter

Overview:
Round-robin arbiter sharing one mult_reduce datapath between NUM_REQ requester streams. Grants one requester at a time for a full burst of NUM_ELEMENTS operand pairs, so accumulations never interleave. Tags each returned dot-product with the owning requester ID through a small in-order ID FIFO. Sits between the per-filter operand sources and the shared mult_reduce instance.

Parameters:
NUM_REQ, 4, number of requester streams (>=2)
DATA_WIDTH, 12, operand width; result width is 2*DATA_WIDTH
NUM_ELEMENTS, 5, beats per burst; matches the mult_reduce instance
ID_FIFO_DEPTH, 2, maximum committed bursts awaiting a result
ID_WIDTH, clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = reset)
req_valid_in  in  NUM_REQ  per-requester operand valid
req_ready_in  out  NUM_REQ  per-requester operand ready
req_dataa_in  in  NUM_REQ*DATA_WIDTH  packed operand A; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_datab_in  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing
mr_valid_out  out  1  operand valid to mult_reduce
mr_ready_out  in  1  mult_reduce input ready
mr_dataa_out  out  DATA_WIDTH  operand A to mult_reduce
mr_datab_out  out  DATA_WIDTH  operand B to mult_reduce
mr_valid_in  in  1  result valid from mult_reduce
mr_ready_in  out  1  result ready to mult_reduce
mr_result_in  in  2*DATA_WIDTH  result from mult_reduce
res_valid_out  out  1  tagged result valid
res_ready_out  in  1  tagged result ready
res_result_out  out  2*DATA_WIDTH  result, passed through
res_id_out  out  ID_WIDTH  owning requester ID
err_out  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, beat count=0, FIFO empty, err_out=0, grant cleared. Combinational outputs settle to 0: req_ready_in, mr_valid_out, res_valid_out. mr_ready_in follows res_ready_out. A partial burst in flight is discarded; mult_reduce shares this reset.
- States: IDLE, BURST.
- IDLE: if any req_valid_in=1 and FIFO occupancy < ID_FIFO_DEPTH, register grant = first requesting index searching rr_ptr, rr_ptr+1, ... with wrap at NUM_REQ; go to BURST next cycle. Otherwise stay in IDLE.
- BURST:
  - mr_valid_out = req_valid_in[grant]; mr_data* = granted slice; req_ready_in[grant] = mr_ready_out; all other ready bits are 0.
  - Beat handshake (mr_valid_out & mr_ready_out) increments count.
  - On the handshake with count == NUM_ELEMENTS-1: push grant into the ID FIFO, count<=0, rr_ptr<=(grant+1) mod NUM_REQ, state<=IDLE.
  - If the granted requester drops valid mid-burst, the grant is held indefinitely (no timeout).
- Minimum one IDLE bubble cycle between bursts.
- Result path, combinational:
  - res_valid_out = mr_valid_in & ~fifo_empty; res_result_out = mr_result_in; res_id_out = FIFO head.
  - mr_ready_in = res_ready_out.
  - Output handshake pops the FIFO.
- FIFO:
  - Occupancy is checked at grant time. A push therefore always fits.
  - Simultaneous push and pop leave occupancy unchanged.
- Error: mr_valid_in=1 while the FIFO is empty sets err_out=1 until reset. In that case res_valid_out=0 and mr_ready_in still follows res_ready_out, so the stray result drains.

Optional Feature:
MULT_REDUCE_ARB_FAST_REGRANT_EN.
- Defined: on the final-beat handshake, the arbiter evaluates the next winner in the same cycle, starting from the updated rr_ptr. The occupancy check includes the push in that cycle. If a winner exists, it goes BURST->BURST with no bubble, giving back-to-back bursts.
- Undefined: the mandatory IDLE bubble applies as above.

Test Plan:
- Req0 only, A=1..5, B=2 each beat, res_ready_out=1 -> one result: res_id_out=0, res_result_out=30; err_out=0.
- All 4 requesters valid continuously -> grant order 0,1,2,3,0; exactly 5 beats each, no interleaving; one bubble cycle between bursts (feature off).
- res_ready_out=0 with depth 2 -> after 2 committed bursts, no third grant (all req_ready_in=0); release res_ready_out -> IDs popped 0 then 1, then granting resumes.
- mr_ready_out toggled 1,0,1,0 during a burst -> count advances only on handshakes; exactly 5 accepted beats; req_ready_in of non-granted requesters stays 0.
- rst=0 asynchronously at beat 3 of req2's burst -> outputs immediately at reset values; after release with req2 and req0 valid -> req0 granted first, count restarts at 0.
- mr_valid_in=1 pulse with FIFO empty -> err_out=1 and held; res_valid_out stays 0; cleared only by rst=0.
